// File: rtl/usb_rx_pkg.sv
// Shared types and defaults for the USB RX packet FIFO.
// Word layout, default sizes and pointer helper.
package usb_rx_pkg;

  localparam int USB_DATA_W    = 8;
  localparam int RX_FIFO_DEPTH = 64;
  localparam int PTR_MAX_W     = 32;

  typedef struct packed {
    logic                  last;
    logic [USB_DATA_W-1:0] data;
  } rx_word_t;

  // Wide increment; callers size-cast back to their pointer width.
  function automatic logic [PTR_MAX_W-1:0] ptr_inc(
    input logic [PTR_MAX_W-1:0] p
  );
    return p + 1'b1;
  endfunction

endpackage

// File: rtl/usb_rx_pkt_fifo_if.sv
// RCU write side and AHB read side of the RX packet FIFO.
// master = RCU/reader, slave = FIFO.
interface usb_rx_pkt_fifo_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              flush;
  logic              w_enable;
  logic [DATA_W-1:0] w_data;
  logic              pkt_commit;
  logic              pkt_discard;
  logic              r_enable;
  logic [DATA_W-1:0] r_data;
  logic              r_last;
  logic              data_loaded;
  logic [CNT_W-1:0]  avail;
  logic [CNT_W-1:0]  occupancy;
  logic [CNT_W-1:0]  pkt_count;
  logic              overflow;
  logic              rd_err;

  modport master (
    output flush, w_enable, w_data,
    output pkt_commit, pkt_discard, r_enable,
    input  r_data, r_last, data_loaded,
    input  avail, occupancy, pkt_count,
    input  overflow, rd_err
  );

  modport slave (
    input  flush, w_enable, w_data,
    input  pkt_commit, pkt_discard, r_enable,
    output r_data, r_last, data_loaded,
    output avail, occupancy, pkt_count,
    output overflow, rd_err
  );

endinterface

// File: rtl/usb_rx_fifo_ram.sv
// Storage array for the RX packet FIFO.
// One word write port, one last-flag set port, async read.
module usb_rx_fifo_ram
  import usb_rx_pkg::*;
#(
  parameter int DATA_W = USB_DATA_W,
  parameter int DEPTH  = RX_FIFO_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W:0]   wdata,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] saddr,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W:0]   rdata
);

  logic [DATA_W:0] mem [DEPTH];

  // Word write, then tag; the tag wins if both hit one entry.
  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    if (set_en)
      mem[saddr][DATA_W] <= 1'b1;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/usb_rx_pkt_fifo.sv
// Packet-aware RX FIFO: speculative writes, commit/rollback,
// show-ahead reads of committed bytes with last-byte tagging.
module usb_rx_pkt_fifo
  import usb_rx_pkg::*;
#(
  parameter int DATA_W = USB_DATA_W,
  parameter int DEPTH  = RX_FIFO_DEPTH
) (
  input  logic clk,
  input  logic rst,
  usb_rx_pkt_fifo_if.slave bus
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int ADDR_W = CNT_W - 1;
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

  typedef logic [CNT_W-1:0] ptr_t;

  function automatic ptr_t inc(input ptr_t p);
    return ptr_t'(ptr_inc(PTR_MAX_W'(p)));
  endfunction

  ptr_t wr, cmt, rd, pkt_cnt;
  logic pkt_ovf, ovf_q, rd_err_q;

  ptr_t            occ, avl, wr_nxt;
  logic            full, loaded, wr_fire;
  logic            ovf_now, do_disc, do_cmt, drop;
  logic            pop, pop_last, pkt_end;
  logic [DATA_W:0] rd_word;
  logic [ADDR_W-1:0] set_addr;

  // Occupancy, commit/rollback decisions for this cycle.
  always_comb begin
    occ      = wr - rd;
    avl      = cmt - rd;
    full     = (occ == FULL_C);
    loaded   = (avl != '0);
    pkt_end  = bus.pkt_commit | bus.pkt_discard;
    ovf_now  = pkt_ovf | (bus.w_enable & full);
    drop     = bus.pkt_commit & ~bus.pkt_discard & ovf_now;
    do_disc  = bus.pkt_discard | drop;
    wr_fire  = bus.w_enable & ~full & ~do_disc;
    wr_nxt   = wr_fire ? inc(wr) : wr;
    do_cmt   = bus.pkt_commit & ~bus.pkt_discard &
               ~ovf_now & (wr_nxt != cmt);
    set_addr = ADDR_W'(wr_nxt - 1'b1);
    pop      = bus.r_enable & loaded;
    pop_last = pop & rd_word[DATA_W];
  end

  // Pointers, packet counter and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr       <= '0;
      cmt      <= '0;
      rd       <= '0;
      pkt_cnt  <= '0;
      pkt_ovf  <= 1'b0;
      ovf_q    <= 1'b0;
      rd_err_q <= 1'b0;
    end else if (bus.flush) begin
      wr       <= '0;
      cmt      <= '0;
      rd       <= '0;
      pkt_cnt  <= '0;
      pkt_ovf  <= 1'b0;
      ovf_q    <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      wr <= do_disc ? cmt : wr_nxt;
      if (do_cmt)
        cmt <= wr_nxt;
      if (pop)
        rd <= inc(rd);
      pkt_cnt <= pkt_cnt + ptr_t'(do_cmt)
                         - ptr_t'(pop_last);
      if (pkt_end)
        pkt_ovf <= 1'b0;
      else if (bus.w_enable & full)
        pkt_ovf <= 1'b1;
      if (drop)
        ovf_q <= 1'b1;
      rd_err_q <= bus.r_enable & ~loaded;
    end
  end

  usb_rx_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk    (clk),
    .we     (wr_fire),
    .waddr  (wr[ADDR_W-1:0]),
    .wdata  ({1'b0, bus.w_data}),
    .set_en (do_cmt),
    .saddr  (set_addr),
    .raddr  (rd[ADDR_W-1:0]),
    .rdata  (rd_word)
  );

  assign bus.r_data      = loaded ? rd_word[DATA_W-1:0] : '0;
  assign bus.r_last      = loaded & rd_word[DATA_W];
  assign bus.data_loaded = loaded;
  assign bus.avail       = avl;
  assign bus.occupancy   = occ;
  assign bus.pkt_count   = pkt_cnt;
  assign bus.overflow    = ovf_q;
  assign bus.rd_err      = rd_err_q;

endmodule

// File: tb/tb_usb_rx_pkt_fifo.sv
// Directed bench for usb_rx_pkt_fifo.
// Big instance (DEPTH=64) and small instance (DEPTH=4).
module tb_usb_rx_pkt_fifo;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  usb_rx_pkt_fifo_if #(.DATA_W(8), .DEPTH(64)) bb();
  usb_rx_pkt_fifo_if #(.DATA_W(8), .DEPTH(4))  sb();

  usb_rx_pkt_fifo #(.DATA_W(8), .DEPTH(64)) u_big (
    .clk (clk),
    .rst (rst),
    .bus (bb)
  );

  usb_rx_pkt_fifo #(.DATA_W(8), .DEPTH(4)) u_small (
    .clk (clk),
    .rst (rst),
    .bus (sb)
  );

  task automatic clr_inputs();
    bb.flush = 0; bb.w_enable = 0; bb.w_data = '0;
    bb.pkt_commit = 0; bb.pkt_discard = 0; bb.r_enable = 0;
    sb.flush = 0; sb.w_enable = 0; sb.w_data = '0;
    sb.pkt_commit = 0; sb.pkt_discard = 0; sb.r_enable = 0;
  endtask

  // One clock on the big instance; called and returns at a negedge.
  task automatic b_cyc(input logic we, input logic [7:0] d,
                       input logic c, input logic x,
                       input logic re);
    bb.w_enable = we; bb.w_data = d;
    bb.pkt_commit = c; bb.pkt_discard = x; bb.r_enable = re;
    @(negedge clk);
    clr_inputs();
  endtask

  task automatic s_cyc(input logic we, input logic [7:0] d,
                       input logic c, input logic x,
                       input logic re, input logic fl);
    sb.w_enable = we; sb.w_data = d;
    sb.pkt_commit = c; sb.pkt_discard = x; sb.r_enable = re;
    sb.flush = fl;
    @(negedge clk);
    clr_inputs();
  endtask

  task automatic test_reset();
    b_cyc(1, 8'h10, 0, 0, 0);
    b_cyc(1, 8'h11, 1, 0, 0);
    s_cyc(1, 8'h20, 1, 0, 0, 0);
    checks++; if (bb.avail !== 7'd2) begin errors++;
      $display("FAIL rst_pre_avail got=%0d exp=2", bb.avail); end
    bb.w_enable = 1; bb.w_data = 8'h12;
    sb.w_enable = 1; sb.w_data = 8'h21;
    rst = 1;
    #1;
    checks++; if (bb.occupancy !== 7'd0) begin errors++;
      $display("FAIL rst_occ got=%0d exp=0", bb.occupancy); end
    checks++; if (bb.avail !== 7'd0) begin errors++;
      $display("FAIL rst_avail got=%0d exp=0", bb.avail); end
    checks++; if (bb.pkt_count !== 7'd0) begin errors++;
      $display("FAIL rst_pkt got=%0d exp=0", bb.pkt_count); end
    checks++; if (bb.data_loaded !== 1'b0) begin errors++;
      $display("FAIL rst_loaded got=%0b exp=0", bb.data_loaded); end
    checks++; if (bb.r_data !== 8'h00) begin errors++;
      $display("FAIL rst_rdata got=%0h exp=0", bb.r_data); end
    checks++; if (bb.r_last !== 1'b0) begin errors++;
      $display("FAIL rst_rlast got=%0b exp=0", bb.r_last); end
    checks++; if (bb.overflow !== 1'b0) begin errors++;
      $display("FAIL rst_ovf got=%0b exp=0", bb.overflow); end
    checks++; if (sb.occupancy !== 3'd0) begin errors++;
      $display("FAIL rst_s_occ got=%0d exp=0", sb.occupancy); end
    @(negedge clk);
    rst = 0;
    clr_inputs();
    @(negedge clk);
    checks++; if (bb.occupancy !== 7'd0) begin errors++;
      $display("FAIL rst_post_occ got=%0d exp=0", bb.occupancy); end
    checks++; if (bb.rd_err !== 1'b0) begin errors++;
      $display("FAIL rst_rderr got=%0b exp=0", bb.rd_err); end
  endtask

  task automatic test_good_pkt();
    logic [7:0] ed [3] = '{8'hA5, 8'h3C, 8'h7E};
    logic       el [3] = '{1'b0, 1'b0, 1'b1};
    b_cyc(1, 8'hA5, 0, 0, 0);
    b_cyc(1, 8'h3C, 0, 0, 0);
    checks++; if (bb.data_loaded !== 1'b0) begin errors++;
      $display("FAIL good_spec_loaded got=%0b exp=0", bb.data_loaded); end
    b_cyc(1, 8'h7E, 1, 0, 0);
    checks++; if (bb.avail !== 7'd3) begin errors++;
      $display("FAIL good_avail got=%0d exp=3", bb.avail); end
    checks++; if (bb.pkt_count !== 7'd1) begin errors++;
      $display("FAIL good_pkt got=%0d exp=1", bb.pkt_count); end
    checks++; if (bb.occupancy !== 7'd3) begin errors++;
      $display("FAIL good_occ got=%0d exp=3", bb.occupancy); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (bb.r_data !== ed[i]) begin errors++;
        $display("FAIL good_rdata%0d got=%0h exp=%0h", i, bb.r_data, ed[i]); end
      checks++; if (bb.r_last !== el[i]) begin errors++;
        $display("FAIL good_rlast%0d got=%0b exp=%0b", i, bb.r_last, el[i]); end
      b_cyc(0, 8'h00, 0, 0, 1);
    end
    checks++; if (bb.pkt_count !== 7'd0) begin errors++;
      $display("FAIL good_pkt_end got=%0d exp=0", bb.pkt_count); end
    checks++; if (bb.data_loaded !== 1'b0) begin errors++;
      $display("FAIL good_loaded_end got=%0b exp=0", bb.data_loaded); end
    checks++; if (bb.r_data !== 8'h00) begin errors++;
      $display("FAIL good_rdata_end got=%0h exp=0", bb.r_data); end
  endtask

  task automatic test_discard();
    logic [7:0] ed [3] = '{8'h11, 8'h22, 8'h99};
    logic       el [3] = '{1'b0, 1'b1, 1'b1};
    b_cyc(1, 8'h11, 0, 0, 0);
    b_cyc(1, 8'h22, 1, 0, 0);
    for (int i = 0; i < 5; i++)
      b_cyc(1, 8'h33 + 8'(i * 8'h11), 0, 0, 0);
    checks++; if (bb.occupancy !== 7'd7) begin errors++;
      $display("FAIL disc_pre_occ got=%0d exp=7", bb.occupancy); end
    b_cyc(1, 8'h88, 0, 1, 0);
    checks++; if (bb.occupancy !== 7'd2) begin errors++;
      $display("FAIL disc_occ got=%0d exp=2", bb.occupancy); end
    checks++; if (bb.avail !== 7'd2) begin errors++;
      $display("FAIL disc_avail got=%0d exp=2", bb.avail); end
    b_cyc(1, 8'h99, 1, 0, 0);
    checks++; if (bb.avail !== 7'd3) begin errors++;
      $display("FAIL disc_avail2 got=%0d exp=3", bb.avail); end
    checks++; if (bb.pkt_count !== 7'd2) begin errors++;
      $display("FAIL disc_pkt got=%0d exp=2", bb.pkt_count); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (bb.r_data !== ed[i]) begin errors++;
        $display("FAIL disc_rdata%0d got=%0h exp=%0h", i, bb.r_data, ed[i]); end
      checks++; if (bb.r_last !== el[i]) begin errors++;
        $display("FAIL disc_rlast%0d got=%0b exp=%0b", i, bb.r_last, el[i]); end
      b_cyc(0, 8'h00, 0, 0, 1);
    end
    checks++; if (bb.pkt_count !== 7'd0) begin errors++;
      $display("FAIL disc_pkt_end got=%0d exp=0", bb.pkt_count); end
    checks++; if (bb.data_loaded !== 1'b0) begin errors++;
      $display("FAIL disc_loaded_end got=%0b exp=0", bb.data_loaded); end
  endtask

  task automatic test_simultaneous();
    b_cyc(1, 8'hAA, 0, 0, 0);
    b_cyc(1, 8'hBB, 1, 1, 0);
    checks++; if (bb.occupancy !== 7'd0) begin errors++;
      $display("FAIL sim_occ got=%0d exp=0", bb.occupancy); end
    checks++; if (bb.avail !== 7'd0) begin errors++;
      $display("FAIL sim_avail got=%0d exp=0", bb.avail); end
    checks++; if (bb.pkt_count !== 7'd0) begin errors++;
      $display("FAIL sim_pkt got=%0d exp=0", bb.pkt_count); end
    b_cyc(0, 8'h00, 0, 0, 1);
    checks++; if (bb.rd_err !== 1'b1) begin errors++;
      $display("FAIL sim_rderr got=%0b exp=1", bb.rd_err); end
    checks++; if (bb.occupancy !== 7'd0) begin errors++;
      $display("FAIL sim_occ2 got=%0d exp=0", bb.occupancy); end
    b_cyc(0, 8'h00, 0, 0, 0);
    checks++; if (bb.rd_err !== 1'b0) begin errors++;
      $display("FAIL sim_rderr_pulse got=%0b exp=0", bb.rd_err); end
    b_cyc(1, 8'hCC, 1, 0, 0);
    checks++; if (bb.avail !== 7'd1) begin errors++;
      $display("FAIL sim_avail2 got=%0d exp=1", bb.avail); end
    checks++; if (bb.r_data !== 8'hCC) begin errors++;
      $display("FAIL sim_rdata got=%0h exp=cc", bb.r_data); end
    checks++; if (bb.r_last !== 1'b1) begin errors++;
      $display("FAIL sim_rlast got=%0b exp=1", bb.r_last); end
    b_cyc(0, 8'h00, 0, 0, 1);
    checks++; if (bb.data_loaded !== 1'b0) begin errors++;
      $display("FAIL sim_loaded got=%0b exp=0", bb.data_loaded); end
  endtask

  task automatic test_overflow();
    logic [7:0] ed [3] = '{8'h01, 8'h02, 8'h03};
    logic       el [3] = '{1'b0, 1'b0, 1'b1};
    s_cyc(1, 8'h01, 0, 0, 0, 0);
    s_cyc(1, 8'h02, 0, 0, 0, 0);
    s_cyc(1, 8'h03, 1, 0, 0, 0);
    s_cyc(1, 8'h04, 0, 0, 0, 0);
    checks++; if (sb.occupancy !== 3'd4) begin errors++;
      $display("FAIL ovf_full_occ got=%0d exp=4", sb.occupancy); end
    s_cyc(1, 8'h05, 0, 0, 0, 0);
    s_cyc(1, 8'h06, 0, 0, 0, 0);
    checks++; if (sb.overflow !== 1'b0) begin errors++;
      $display("FAIL ovf_early got=%0b exp=0", sb.overflow); end
    s_cyc(1, 8'h07, 1, 0, 0, 0);
    checks++; if (sb.overflow !== 1'b1) begin errors++;
      $display("FAIL ovf_flag got=%0b exp=1", sb.overflow); end
    checks++; if (sb.occupancy !== 3'd3) begin errors++;
      $display("FAIL ovf_occ got=%0d exp=3", sb.occupancy); end
    checks++; if (sb.pkt_count !== 3'd1) begin errors++;
      $display("FAIL ovf_pkt got=%0d exp=1", sb.pkt_count); end
    checks++; if (sb.avail !== 3'd3) begin errors++;
      $display("FAIL ovf_avail got=%0d exp=3", sb.avail); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (sb.r_data !== ed[i]) begin errors++;
        $display("FAIL ovf_rdata%0d got=%0h exp=%0h", i, sb.r_data, ed[i]); end
      checks++; if (sb.r_last !== el[i]) begin errors++;
        $display("FAIL ovf_rlast%0d got=%0b exp=%0b", i, sb.r_last, el[i]); end
      s_cyc(0, 8'h00, 0, 0, 1, 0);
    end
    s_cyc(1, 8'h08, 1, 0, 0, 0);
    checks++; if (sb.avail !== 3'd1) begin errors++;
      $display("FAIL ovf_next_avail got=%0d exp=1", sb.avail); end
    checks++; if (sb.r_data !== 8'h08) begin errors++;
      $display("FAIL ovf_next_rdata got=%0h exp=8", sb.r_data); end
    checks++; if (sb.overflow !== 1'b1) begin errors++;
      $display("FAIL ovf_sticky got=%0b exp=1", sb.overflow); end
    s_cyc(0, 8'h00, 0, 0, 1, 0);
  endtask

  task automatic test_wrap_flush();
    logic [7:0] d;
    for (int i = 0; i < 10; i++) begin
      d = 8'h30 + 8'(i);
      s_cyc(1, d, 1, 0, 0, 0);
      checks++; if (sb.r_data !== d) begin errors++;
        $display("FAIL wrap_rdata%0d got=%0h exp=%0h", i, sb.r_data, d); end
      checks++; if (sb.r_last !== 1'b1) begin errors++;
        $display("FAIL wrap_rlast%0d got=%0b exp=1", i, sb.r_last); end
      checks++; if (sb.pkt_count !== 3'd1) begin errors++;
        $display("FAIL wrap_pkt%0d got=%0d exp=1", i, sb.pkt_count); end
      s_cyc(0, 8'h00, 0, 0, 1, 0);
      checks++; if (sb.data_loaded !== 1'b0) begin errors++;
        $display("FAIL wrap_loaded%0d got=%0b exp=0", i, sb.data_loaded); end
    end
    s_cyc(1, 8'hE0, 1, 0, 0, 0);
    s_cyc(1, 8'hE1, 0, 0, 0, 0);
    checks++; if (sb.occupancy !== 3'd2) begin errors++;
      $display("FAIL flush_pre_occ got=%0d exp=2", sb.occupancy); end
    s_cyc(1, 8'hE2, 1, 0, 1, 1);
    checks++; if (sb.occupancy !== 3'd0) begin errors++;
      $display("FAIL flush_occ got=%0d exp=0", sb.occupancy); end
    checks++; if (sb.avail !== 3'd0) begin errors++;
      $display("FAIL flush_avail got=%0d exp=0", sb.avail); end
    checks++; if (sb.pkt_count !== 3'd0) begin errors++;
      $display("FAIL flush_pkt got=%0d exp=0", sb.pkt_count); end
    checks++; if (sb.overflow !== 1'b0) begin errors++;
      $display("FAIL flush_ovf got=%0b exp=0", sb.overflow); end
    checks++; if (sb.r_data !== 8'h00) begin errors++;
      $display("FAIL flush_rdata got=%0h exp=0", sb.r_data); end
    s_cyc(1, 8'hF0, 1, 0, 0, 0);
    checks++; if (sb.r_data !== 8'hF0) begin errors++;
      $display("FAIL flush_after got=%0h exp=f0", sb.r_data); end
  endtask

  initial begin
    rst = 1;
    clr_inputs();
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    test_reset();
    test_good_pkt();
    test_discard();
    test_simultaneous();
    test_overflow();
    test_wrap_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
